mmcarb: RTL

- Arbitrates the single MMC sector cache (mmccon plus its 512-byte sector RAM) between two requesters.
  - Requester 0: memcon/CPU path.
  - Requester 1: boot/video loader.
- Sequences the winner's 23-bit block number into mmccon's byte-wide CORE register port and waits for the sector to become resident.
- Grants the sector RAM port to the winner until it releases the request.
- Tracks the dirty state that mmccon uses to decide on write-back.

---
 rtl/mmcarb_pkg.sv | 24 ++
 rtl/mmcarb_if.sv | 28 ++
 rtl/mmcarb_rr.sv | 15 +
 rtl/mmcarb.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mmcarb_pkg.sv
// Shared mmccon arbiter definitions: FSM encoding, mmccon CORE register indices, block width.
package mmcarb_pkg;

  localparam int BLK_W = 23;

  // mmccon CORE register indices for the three block-number bytes
  localparam logic [1:0] MMC_REG_BLK_LO  = 2'd1;
  localparam logic [1:0] MMC_REG_BLK_MID = 2'd2;
  localparam logic [1:0] MMC_REG_BLK_HI  = 2'd3;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [2:0] {
    MMCARB_IDLE,
    MMCARB_CHECK,
    MMCARB_WR1,
    MMCARB_WR2,
    MMCARB_WR3,
    MMCARB_SETTLE,
    MMCARB_WAIT,
    MMCARB_OWN
  } state_t;

endpackage

// File: rtl/mmcarb_if.sv
// Requester, mmccon CORE and sector RAM arbitration signals of mmcarb.
interface mmcarb_if;
  import mmcarb_pkg::*;

  logic       req0, we0, ack0;
  blk_t       blk0;
  logic       req1, we1, ack1;
  blk_t       blk1;
  logic [1:0] gnt;
  logic       err;
  blk_t       mmc_block;
  logic       mmc_ready;
  logic       core_we;
  logic [1:0] core_addr;
  logic [7:0] core_d;
  logic       ram_dirty;

  modport slave (
    input  req0, blk0, we0, req1, blk1, we1, mmc_block, mmc_ready,
    output ack0, ack1, gnt, err, core_we, core_addr, core_d, ram_dirty
  );

  modport master (
    output req0, blk0, we0, req1, blk1, we1, mmc_block, mmc_ready,
    input  ack0, ack1, gnt, err, core_we, core_addr, core_d, ram_dirty
  );

endinterface

// File: rtl/mmcarb_rr.sv
// Two-input round-robin picker: a tie goes to the requester that did not own last.
// Latency: combinational, zero cycles.
// Backpressure: none; the loser simply keeps its request level high.
module mmcarb_rr (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_win,
  output logic o_vld
);

  assign o_vld = i_req0 | i_req1;
  assign o_win = (i_req0 && i_req1) ? ~i_rr_last : i_req1;

endmodule

// File: rtl/mmcarb.sv
// Arbitrates mmccon and its sector RAM between two requesters; MMCARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: ACK two cycles after REQ on a hit; a miss adds three CORE writes, SETTLE and the mmccon load.
// Backpressure: REQ is a held level; the non-winner stays pending until the owner releases.
module mmcarb
  import mmcarb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50000000
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  mmcarb_if.slave bus
);

  state_t     r_state, w_next;
  blk_t       r_tgt;
  logic       r_win, r_rr_last, r_dirty;
  logic       r_ack0, r_ack1, r_core_we;
  logic [1:0] r_gnt, r_core_addr;
  logic [7:0] r_core_d;
  logic       w_rr_win, w_rr_vld, w_req_win, w_we_win, w_blk_match, w_hit;
  logic       w_timeout, w_err;
  logic       w_core_we;
  logic [1:0] w_core_addr, w_gnt;
  logic [7:0] w_core_d;

  mmcarb_rr u_rr (
    .i_req0    (bus.req0),
    .i_req1    (bus.req1),
    .i_rr_last (r_rr_last),
    .o_win     (w_rr_win),
    .o_vld     (w_rr_vld)
  );

  assign w_req_win   = r_win ? bus.req1 : bus.req0;
  assign w_we_win    = r_win ? bus.we1  : bus.we0;
  assign w_blk_match = (bus.mmc_block == r_tgt);
  assign w_hit       = bus.mmc_ready && w_blk_match;

`ifdef MMCARB_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_err;

  assign w_timeout = (r_state == MMCARB_WAIT) && (r_cnt == TIMEOUT - 32'd1) && !w_hit;
  assign w_err     = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 32'd0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == MMCARB_WAIT) ? r_cnt + 32'd1 : 32'd0;
      if (r_state == MMCARB_IDLE && w_next == MMCARB_CHECK)
        r_err <= 1'b0;
      else if (w_timeout && w_next == MMCARB_OWN)
        r_err <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT blocks until mmccon answers; TIMEOUT is only folded away here.
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0 & (|TIMEOUT);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MMCARB_IDLE;
    else          r_state <= w_next;
  end

  // Any state before OWN abandons a requester that has dropped REQ.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MMCARB_IDLE:   if (w_rr_vld) w_next = MMCARB_CHECK;
      MMCARB_CHECK:  w_next = !w_req_win ? MMCARB_IDLE : (w_hit ? MMCARB_OWN : MMCARB_WR1);
      MMCARB_WR1:    w_next = w_req_win ? MMCARB_WR2    : MMCARB_IDLE;
      MMCARB_WR2:    w_next = w_req_win ? MMCARB_WR3    : MMCARB_IDLE;
      MMCARB_WR3:    w_next = w_req_win ? MMCARB_SETTLE : MMCARB_IDLE;
      MMCARB_SETTLE: w_next = w_req_win ? MMCARB_WAIT   : MMCARB_IDLE;
      MMCARB_WAIT: begin
        if (!w_req_win)              w_next = MMCARB_IDLE;
        else if (w_hit || w_timeout) w_next = MMCARB_OWN;
      end
      MMCARB_OWN:    if (!w_req_win) w_next = MMCARB_IDLE;
      default:       w_next = MMCARB_IDLE;
    endcase
  end

  always_comb begin
    w_core_we   = 1'b0;
    w_core_addr = 2'd0;
    w_core_d    = 8'd0;
    w_gnt       = 2'b00;
    case (w_next)
      MMCARB_WR1: begin
        w_core_we   = 1'b1;
        w_core_addr = MMC_REG_BLK_LO;
        w_core_d    = {r_tgt[6:0], 1'b0};
      end
      MMCARB_WR2: begin
        w_core_we   = 1'b1;
        w_core_addr = MMC_REG_BLK_MID;
        w_core_d    = r_tgt[14:7];
      end
      MMCARB_WR3: begin
        w_core_we   = 1'b1;
        w_core_addr = MMC_REG_BLK_HI;
        w_core_d    = r_tgt[22:15];
      end
      MMCARB_OWN: w_gnt = r_win ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_core_we   <= 1'b0;
      r_core_addr <= 2'd0;
      r_core_d    <= 8'd0;
      r_gnt       <= 2'b00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
    end else begin
      r_core_we   <= w_core_we;
      r_core_addr <= w_core_addr;
      r_core_d    <= w_core_d;
      r_gnt       <= w_gnt;
      r_ack0      <= w_gnt[0];
      r_ack1      <= w_gnt[1];
    end
  end

  // mmccon only moves BLOCK after any write-back, so a match in WAIT means the old data is gone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt     <= '0;
      r_win     <= 1'b0;
      r_rr_last <= 1'b1;
      r_dirty   <= 1'b0;
    end else begin
      if (r_state == MMCARB_IDLE && w_rr_vld) begin
        r_tgt <= w_rr_win ? bus.blk1 : bus.blk0;
        r_win <= w_rr_win;
      end
      if (r_state == MMCARB_OWN) r_rr_last <= r_win;
      if (r_state == MMCARB_WAIT && w_blk_match)
        r_dirty <= 1'b0;
      else if (r_state == MMCARB_OWN && w_we_win)
        r_dirty <= 1'b1;
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.gnt       = r_gnt;
  assign bus.err       = w_err;
  assign bus.core_we   = r_core_we;
  assign bus.core_addr = r_core_addr;
  assign bus.core_d    = r_core_d;
  assign bus.ram_dirty = r_dirty;

endmodule
